// File: rtl/l2_tcdm_fill_check_master.sv
// ---------------------------------------------------------------------------
// l2_tcdm_fill_check_master
//
// TCDM initiator that walks a word-aligned L2 address range. In fill mode it
// writes the pattern (address ^ seed) to every word. In check mode it reads
// every word back, compares it with that pattern and counts mismatches.
// Several requests may be in flight at once, up to MAX_OUTSTANDING.
// Responses are assumed to return in order.
//
// Optional feature macro: L2_FILL_CHECK_ERR_LOG_EN
//   defined   : first_err_addr_o records the address of the first mismatch
//               seen in a check run.
//   undefined : first_err_addr_o is tied to 0 and has no capture register.
//
// Parameters
//   MAX_OUTSTANDING  max issued-but-unanswered requests (power of two, 1..16)
//   CNT_WIDTH        width of the word-count and error-count registers
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            one-cycle start pulse, honoured only in IDLE
//   mode_i             0 = fill, 1 = check (sampled with start_i)
//   base_addr_i        byte start address, bits [1:0] forced to 0
//   num_words_i        number of 32-bit words (sampled with start_i)
//   seed_i             pattern seed (sampled with start_i)
//   busy_o             high from the cycle after an accepted start until done_o
//   done_o             one-cycle completion pulse
//   err_count_o        saturating mismatch count of the last run
//   first_err_addr_o   address of the first mismatch (see macro above)
//   tcdm_*             XBAR_TCDM_BUS-style master port
// ---------------------------------------------------------------------------
module l2_tcdm_fill_check_master #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [31:0]          first_err_addr_o,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_wdata_o,
  input  logic                 tcdm_gnt_i,
  input  logic                 tcdm_r_valid_i,
  input  logic [31:0]          tcdm_r_rdata_i,
  input  logic                 tcdm_r_opc_i
);

  // Outstanding counter must be able to hold MAX_OUTSTANDING itself.
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q;
  logic                 mode_q;
  logic [31:0]          seed_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] issued_q;
  logic [CNT_WIDTH-1:0] err_q;
  logic [OW-1:0]        out_q;
  logic [31:0]          add_q;      // next request address
  logic [31:0]          rsp_add_q;  // address the next response belongs to
  logic                 req_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 grant;
  logic                 rsp;
  logic                 mismatch;
  logic                 active;
  logic                 start_run;
  logic [OW-1:0]        out_d;
  logic [CNT_WIDTH-1:0] issued_d;
  logic [31:0]          base_aligned;

  // The two low address bits are dropped on purpose: every access is a full word.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^base_addr_i[1:0];
  assign base_aligned     = {base_addr_i[31:2], 2'b00};

  assign active    = (state_q == ISSUE) || (state_q == DRAIN);
  assign start_run = (state_q == IDLE) && start_i && (num_words_i != '0);
  assign grant     = req_q && tcdm_gnt_i;

  // A response with nothing outstanding (or arriving outside a run, e.g.
  // straggling in after a reset) is a protocol violation and is dropped.
  assign rsp = tcdm_r_valid_i && active && (out_q != '0);

  // A bus error counts in both modes; data is only compared in check mode.
  assign mismatch = rsp && (tcdm_r_opc_i ||
                            (mode_q && (tcdm_r_rdata_i != (rsp_add_q ^ seed_q))));

  // Grant and response in the same cycle cancel out.
  always_comb begin
    out_d = out_q;
    if (grant && !rsp) begin
      out_d = out_q + 1'b1;
    end else if (!grant && rsp) begin
      out_d = out_q - 1'b1;
    end
  end

  assign issued_d = grant ? (issued_q + 1'b1) : issued_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      seed_q    <= '0;
      num_q     <= '0;
      issued_q  <= '0;
      err_q     <= '0;
      out_q     <= '0;
      add_q     <= '0;
      rsp_add_q <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Response bookkeeping is shared by ISSUE and DRAIN (rsp is 0 elsewhere).
      if (rsp) begin
        rsp_add_q <= rsp_add_q + 32'd4;
      end
      if (mismatch && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q    <= mode_i;
            seed_q    <= seed_i;
            num_q     <= num_words_i;
            add_q     <= base_aligned;
            rsp_add_q <= base_aligned;
            issued_q  <= '0;
            out_q     <= '0;
            busy_q    <= 1'b1;
            if (num_words_i == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= ISSUE;
              err_q   <= '0;
              // Nothing is outstanding yet, so the first request goes out
              // in the very first ISSUE cycle.
              req_q   <= 1'b1;
            end
          end
        end

        ISSUE: begin
          issued_q <= issued_d;
          out_q    <= out_d;
          if (grant) begin
            add_q <= add_q + 32'd4;  // 32-bit wrap is intended
          end
          if (grant && (issued_d == num_q)) begin
            req_q   <= 1'b0;
            state_q <= DRAIN;
          end else begin
            // A pending request is held until granted; otherwise a new one is
            // raised when words remain and the in-flight window has room.
            req_q <= (req_q && !grant) ||
                     ((issued_d < num_q) && (out_d < MAX_OUT));
          end
        end

        DRAIN: begin
          out_q <= out_d;
          // Looking at the next value lets the last response close the run
          // without an extra idle cycle.
          if (out_d == '0) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef L2_FILL_CHECK_ERR_LOG_EN
  logic [31:0] first_err_q;

  // Only data mismatches of a check run are logged; the first one wins
  // because err_q is still zero at that moment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_err_q <= '0;
    end else if (start_run) begin
      first_err_q <= '0;
    end else if (mismatch && mode_q && (err_q == '0)) begin
      first_err_q <= rsp_add_q;
    end
  end

  assign first_err_addr_o = first_err_q;
`else
  assign first_err_addr_o = '0;
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_count_o  = err_q;
  assign tcdm_req_o   = req_q;
  assign tcdm_add_o   = add_q;
  assign tcdm_wen_o   = mode_q;
  assign tcdm_be_o    = 4'hF;
  // Derived from registers only, so it is stable whenever the address is.
  assign tcdm_wdata_o = add_q ^ seed_q;

endmodule

// File: tb/tb_l2_tcdm_fill_check_master.sv
module tb_l2_tcdm_fill_check_master;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] num_words_i = '0;
  logic [31:0] seed_i = '0;
  logic        busy_o, done_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;
  logic        tcdm_req_o, tcdm_wen_o;
  logic [31:0] tcdm_add_o, tcdm_wdata_o;
  logic [3:0]  tcdm_be_o;
  logic        tcdm_gnt_i = 1'b0;
  logic        tcdm_r_valid_i = 1'b0;
  logic [31:0] tcdm_r_rdata_i = '0;
  logic        tcdm_r_opc_i = 1'b0;

  always #5 clk = ~clk;

  l2_tcdm_fill_check_master #(
    .MAX_OUTSTANDING(MAXO),
    .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .mode_i(mode_i),
    .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
    .seed_i(seed_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o),
    .tcdm_req_o(tcdm_req_o),
    .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o),
    .tcdm_wdata_o(tcdm_wdata_o),
    .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_rdata_i(tcdm_r_rdata_i),
    .tcdm_r_opc_i(tcdm_r_opc_i)
  );

  typedef struct {
    logic [31:0] add;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        opc;
  } rsp_t;

  req_t        grants[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem [bit [31:0]];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          rand_gnt = 1'b0;
  int          rsp_delay = 1;
  int          opc_idx = -1;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
  int          max_out = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_add = '0;
  logic [31:0] stall_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Memory content as returned on a read, including a planted corruption.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    logic [31:0] v;
    v = mem.exists(a) ? mem[a] : 32'h0;
    if (corrupt_en && (a == corrupt_addr)) v = v ^ 32'h0000_0001;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: inputs for the cycle are settled 1 time unit after negedge.
  always @(negedge clk) begin
    rsp_t r;
    req_t g;
    #1;
    if ((rsp_q.size() > 0) && (rsp_q[0].due <= cyc)) begin
      r = rsp_q.pop_front();
      tcdm_r_valid_i = 1'b1;
      tcdm_r_rdata_i = r.rdata;
      tcdm_r_opc_i   = r.opc;
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_rdata_i = $urandom;
      tcdm_r_opc_i   = 1'b0;
    end
    tcdm_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;

    if (stall_prev) begin
      chk("stall_req", 32'(tcdm_req_o), 32'd1);
      chk("stall_add", tcdm_add_o, stall_add);
      chk("stall_wdata", tcdm_wdata_o, stall_wdata);
    end

    if (tcdm_req_o && tcdm_gnt_i) begin
      g.add = tcdm_add_o; g.wdata = tcdm_wdata_o; g.wen = tcdm_wen_o; g.be = tcdm_be_o;
      grants.push_back(g);
      r.due   = cyc + rsp_delay;
      r.opc   = ((grants.size() - 1) == opc_idx);
      r.rdata = tcdm_wen_o ? rd_model(tcdm_add_o) : 32'h0;
      if (!tcdm_wen_o) mem[tcdm_add_o] = tcdm_wdata_o;
      rsp_q.push_back(r);
    end
    if (rsp_q.size() > max_out) max_out = rsp_q.size();

    stall_prev  = tcdm_req_o && !tcdm_gnt_i && !rst_i;
    stall_add   = tcdm_add_o;
    stall_wdata = tcdm_wdata_o;
  end

  task automatic start_run(input logic m, input logic [31:0] base, input int n,
                           input logic [31:0] seed, output int s);
    grants.delete();
    max_out = 0;
    @(negedge clk);
    mode_i = m; base_addr_i = base; num_words_i = n[15:0]; seed_i = seed; start_i = 1'b1;
    s = cyc;
    @(negedge clk);
    start_i = 1'b0;
    // Scramble the inputs so a design that fails to latch them is caught.
    mode_i = ~m; base_addr_i = $urandom; num_words_i = 16'($urandom); seed_i = $urandom;
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input string name, input int s, output int lat);
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done_o) begin
        lat = cyc - s;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, 32'(lat >= 0), 32'd1);
    if (lat >= 0) begin
      chk({name, "_busy_low_at_done"}, 32'(busy_o), 32'd0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, 32'(done_o), 32'd0);
    end
    // Let any straggling responses leave before the next run.
    for (int k = 0; k < 50 && rsp_q.size() > 0; k++) @(negedge clk);
  endtask

  task automatic check_grants(input string name, input logic [31:0] base, input int n,
                              input logic [31:0] seed, input logic rd);
    logic [31:0] a;
    chk({name, "_grant_count"}, 32'(grants.size()), 32'(n));
    for (int i = 0; i < n && i < grants.size(); i++) begin
      a = base + 32'(4 * i);
      chk({name, "_add"}, grants[i].add, a);
      chk({name, "_wen"}, 32'(grants[i].wen), 32'(rd));
      chk({name, "_be"}, 32'(grants[i].be), 32'hF);
      if (!rd) begin
        chk({name, "_wdata"}, grants[i].wdata, a ^ seed);
        chk({name, "_mem"}, mem.exists(a) ? mem[a] : 32'hDEAD_BEEF, a ^ seed);
      end
    end
  endtask

  task automatic expect_check(input logic [31:0] base, input int n, input logic [31:0] seed,
                              output int errs, output logic [31:0] first);
    logic [31:0] a;
    errs = 0; first = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      if ((rd_model(a) !== (a ^ seed)) || (i == opc_idx)) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
`ifndef L2_FILL_CHECK_ERR_LOG_EN
    first = 32'h0;
`endif
  endtask

  initial begin
    int s, lat, errs, n, nw;
    logic [31:0] first, base, seed;

    #200;
    $display("tb: watchdog armed");
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, lat, errs, n;
    logic [31:0] first, base, seed, raw;

    // Reset state
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(tcdm_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_count_o), 32'd0);
    chk("rst_first", first_err_addr_o, 32'd0);
    chk("rst_add", tcdm_add_o, 32'd0);

    // Fill, gnt always 1, 1-cycle responses
    base = 32'h1C01_0000; seed = 32'hA5A5_A5A5;
    start_run(1'b0, base, 16, seed, s);
    wait_done("fill16", s, lat);
    chk("fill16_latency", 32'(lat), 32'd19);
    chk("fill16_err", 32'(err_count_o), 32'd0);
    check_grants("fill16", base, 16, seed, 1'b0);
    chk("fill16_word8", mem[32'h1C01_0008], 32'h1C01_0008 ^ 32'hA5A5_A5A5);
    $display("run fill   base=%08h n=16 seed=%08h latency=%0d err=%0d", base, seed, lat, err_count_o);

    // Check with one corrupted word
    corrupt_en = 1'b1; corrupt_addr = 32'h1C01_0020;
    expect_check(base, 16, seed, errs, first);
    start_run(1'b1, base, 16, seed, s);
    wait_done("check16", s, lat);
    chk("check16_err", 32'(err_count_o), 32'(errs));
    chk("check16_first", first_err_addr_o, first);
    check_grants("check16", base, 16, seed, 1'b1);
    corrupt_en = 1'b0;
    $display("run check  base=%08h n=16 err=%0d first=%08h", base, err_count_o, first_err_addr_o);

    // Random stalls and delayed responses, fill then check
    rand_gnt = 1'b1;
    for (int r = 0; r < 3; r++) begin
      raw  = $urandom;
      base = {raw[31:2], 2'b00};
      seed = $urandom;
      n    = (r == 0) ? 64 : $urandom_range(1, 40);
      rsp_delay = (r == 0) ? 3 : $urandom_range(1, 4);
      start_run(1'b0, raw, n, seed, s);
      wait_done("rnd_fill", s, lat);
      chk("rnd_fill_err", 32'(err_count_o), 32'd0);
      chk("rnd_fill_maxout", 32'(max_out <= MAXO), 32'd1);
      check_grants("rnd_fill", base, n, seed, 1'b0);
      corrupt_en   = (r == 2);
      corrupt_addr = base + 32'(4 * $urandom_range(0, n - 1));
      expect_check(base, n, seed, errs, first);
      start_run(1'b1, raw, n, seed, s);
      wait_done("rnd_check", s, lat);
      chk("rnd_check_err", 32'(err_count_o), 32'(errs));
      chk("rnd_check_first", first_err_addr_o, first);
      chk("rnd_check_maxout", 32'(max_out <= MAXO), 32'd1);
      corrupt_en = 1'b0;
      $display("run random base=%08h n=%0d delay=%0d maxout=%0d err=%0d", base, n, rsp_delay, max_out, err_count_o);
    end
    rand_gnt = 1'b0; rsp_delay = 1;

    // Zero words
    start_run(1'b0, 32'h1C00_0000, 0, 32'h1234_5678, s);
    wait_done("zero", s, lat);
    chk("zero_latency", 32'(lat), 32'd2);
    chk("zero_no_req", 32'(grants.size()), 32'd0);
    $display("run zero   latency=%0d", lat);

    // Reset in the middle of a 32-word run
    start_run(1'b0, 32'h1C03_0000, 32, 32'h0F0F_0F0F, s);
    for (int k = 0; k < 200 && grants.size() < 5; k++) @(negedge clk);
    chk("mid_reached_word5", 32'(grants.size() >= 5), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_rst_req", 32'(tcdm_req_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_err", 32'(err_count_o), 32'd0);
    for (int k = 0; k < 20 && rsp_q.size() > 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("late_rsp_busy", 32'(busy_o), 32'd0);
    chk("late_rsp_done", 32'(done_o), 32'd0);
    chk("late_rsp_err", 32'(err_count_o), 32'd0);
    base = 32'h1C04_0000; seed = 32'h5A5A_0001;
    start_run(1'b0, base, 8, seed, s);
    wait_done("after_rst", s, lat);
    chk("after_rst_latency", 32'(lat), 32'd11);
    chk("after_rst_err", 32'(err_count_o), 32'd0);
    check_grants("after_rst", base, 8, seed, 1'b0);
    $display("run reset  restart latency=%0d err=%0d", lat, err_count_o);

    // Address wrap with a bus error on the third response
    base = 32'hFFFF_FFF8; seed = 32'h0000_00FF; opc_idx = 2;
    start_run(1'b0, base, 4, seed, s);
    wait_done("wrap", s, lat);
    chk("wrap_add0", grants[0].add, 32'hFFFF_FFF8);
    chk("wrap_add1", grants[1].add, 32'hFFFF_FFFC);
    chk("wrap_add2", grants[2].add, 32'h0000_0000);
    chk("wrap_add3", grants[3].add, 32'h0000_0004);
    chk("wrap_err_opc", 32'(err_count_o), 32'd1);
    check_grants("wrap", base, 4, seed, 1'b0);
    opc_idx = -1;
    $display("run wrap   base=%08h n=4 err=%0d", base, err_count_o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
